// File: rtl/windowed_reg_file_if.sv
// rtl/windowed_reg_file_if.sv - datapath-side bus of the windowed register file
interface windowed_reg_file_if #(
   parameter int DATA_W   = 32,
   parameter int NWINDOWS = 4,
   parameter int CWP_W    = $clog2(NWINDOWS)
);
   logic [4:0]          RA;
   logic [4:0]          RB;
   logic [DATA_W-1:0]   PA;
   logic [DATA_W-1:0]   PB;
   logic [4:0]          C;
   logic [DATA_W-1:0]   PC;
   logic                Ld;
   logic                Save;
   logic                Restore;
   logic                Cwp_ld;
   logic [CWP_W-1:0]    Cwp_in;
   logic                Wim_ld;
   logic [NWINDOWS-1:0] Wim_in;
   logic [CWP_W-1:0]    Cwp;
   logic [NWINDOWS-1:0] Wim;
   logic                Wovf;
   logic                Wunf;
   logic                Busy;

   modport master (
      output RA, RB, C, PC, Ld, Save, Restore, Cwp_ld, Cwp_in, Wim_ld, Wim_in,
      input  PA, PB, Cwp, Wim, Wovf, Wunf, Busy
   );

   modport slave (
      input  RA, RB, C, PC, Ld, Save, Restore, Cwp_ld, Cwp_in, Wim_ld, Wim_in,
      output PA, PB, Cwp, Wim, Wovf, Wunf, Busy
   );
endinterface

// File: rtl/windowed_reg_file.sv
// rtl/windowed_reg_file.sv - SPARC-style windowed register file with CWP/WIM and clear sequencer
module windowed_reg_file #(
   parameter int DATA_W   = 32,
   parameter int NWINDOWS = 4,
   parameter int CWP_W    = $clog2(NWINDOWS)
) (
   input logic              Clk,
   input logic              Clr_n,
   windowed_reg_file_if.slave bus
);

   localparam int unsigned WIN   = 16 * NWINDOWS;
   localparam int unsigned NPHYS = 8 + WIN;
   localparam int unsigned NW_U  = NWINDOWS;
   localparam int          IDX_W = $clog2(NPHYS);

   localparam logic [CWP_W-1:0] CWP_MAX  = CWP_W'(NWINDOWS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPHYS - 1);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                busy;
   logic                clear_we;

   logic [CWP_W-1:0]    cwp_q, cwp_d;
   logic [CWP_W-1:0]    cwp_dec, cwp_inc, cwp_ld_val;
   logic [NWINDOWS-1:0] wim_q, wim_d;
   logic                wovf_q, wovf_d;
   logic                wunf_q, wunf_d;

   logic                wr_en;
   logic [IDX_W-1:0]    wr_addr;
   logic [DATA_W-1:0]   regs_q [NPHYS];

   // Window registers wrap once at most: 16*cwp + (r-8) never reaches 2*WIN.
   function automatic logic [IDX_W-1:0] map_reg(input logic [4:0] r,
                                                input logic [CWP_W-1:0] cwp);
      logic [31:0] off;
      if (r < 5'd8) return IDX_W'(r);
      off = 32'(cwp) * 32'd16 + 32'(r) - 32'd8;
      if (off >= WIN) off = off - WIN;
      return IDX_W'(off + 32'd8);
   endfunction

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
         state_q <= S_CLEAR;
         idx_q   <= IDX_W'(1);
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_CLEAR: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = S_READY;
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      case (state_q)
         S_CLEAR: busy = 1'b1;
         default: ;
      endcase
      clear_we = busy;
   end

   assign cwp_dec    = (cwp_q == '0)      ? CWP_MAX : cwp_q - 1'b1;
   assign cwp_inc    = (cwp_q == CWP_MAX) ? '0      : cwp_q + 1'b1;
   assign cwp_ld_val = (32'(bus.Cwp_in) >= NW_U) ? CWP_W'(32'(bus.Cwp_in) - NW_U)
                                                 : bus.Cwp_in;

   // Trap checks look at the pre-edge WIM even when Wim_ld fires this cycle.
   always_comb begin
      cwp_d  = cwp_q;
      wim_d  = wim_q;
      wovf_d = 1'b0;
      wunf_d = 1'b0;
      if (!busy) begin
         if (bus.Wim_ld) wim_d = bus.Wim_in;
         if (bus.Cwp_ld) begin
            cwp_d = cwp_ld_val;
         end else if (bus.Save != bus.Restore) begin
            if (bus.Save) begin
               if (wim_q[cwp_dec]) wovf_d = 1'b1;
               else                cwp_d  = cwp_dec;
            end else begin
               if (wim_q[cwp_inc]) wunf_d = 1'b1;
               else                cwp_d  = cwp_inc;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
         cwp_q  <= '0;
         wim_q  <= '0;
         wovf_q <= 1'b0;
         wunf_q <= 1'b0;
      end else begin
         cwp_q  <= cwp_d;
         wim_q  <= wim_d;
         wovf_q <= wovf_d;
         wunf_q <= wunf_d;
      end
   end

   assign wr_en   = !busy && bus.Ld && (bus.C != 5'd0);
   assign wr_addr = map_reg(bus.C, cwp_q);

   always_ff @(posedge Clk) begin
      if (clear_we)   regs_q[idx_q]   <= '0;
      else if (wr_en) regs_q[wr_addr] <= bus.PC;
   end

   assign bus.PA   = (busy || bus.RA == 5'd0) ? '0 : regs_q[map_reg(bus.RA, cwp_q)];
   assign bus.PB   = (busy || bus.RB == 5'd0) ? '0 : regs_q[map_reg(bus.RB, cwp_q)];
   assign bus.Cwp  = cwp_q;
   assign bus.Wim  = wim_q;
   assign bus.Wovf = wovf_q;
   assign bus.Wunf = wunf_q;
   assign bus.Busy = busy;

endmodule

// File: tb/tb_windowed_reg_file.sv
// tb/tb_windowed_reg_file.sv - directed vector bench for windowed_reg_file
module tb_windowed_reg_file;

   logic clk = 1'b0;
   logic clr_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   windowed_reg_file_if #(.DATA_W(32), .NWINDOWS(4), .CWP_W(2)) bus ();

   windowed_reg_file #(.DATA_W(32), .NWINDOWS(4), .CWP_W(2)) dut (
      .Clk   (clk),
      .Clr_n (clr_n),
      .bus   (bus)
   );

   typedef struct {
      logic        ld;
      logic [4:0]  c;
      logic [31:0] pc;
      logic        save;
      logic        restore;
      logic        cwp_ld;
      logic [1:0]  cwp_in;
      logic        wim_ld;
      logic [3:0]  wim_in;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] exp_pa;
      logic [31:0] exp_pb;
      logic [1:0]  exp_cwp;
      logic [3:0]  exp_wim;
      logic        exp_wovf;
      logic        exp_wunf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ld, logic [4:0] c, logic [31:0] pc,
                               logic save, logic restore, logic cwp_ld, logic [1:0] cwp_in,
                               logic wim_ld, logic [3:0] wim_in, logic [4:0] ra, logic [4:0] rb,
                               logic [31:0] exp_pa, logic [31:0] exp_pb, logic [1:0] exp_cwp,
                               logic [3:0] exp_wim, logic exp_wovf, logic exp_wunf);
      vec_t v;
      v.ld = ld; v.c = c; v.pc = pc; v.save = save; v.restore = restore;
      v.cwp_ld = cwp_ld; v.cwp_in = cwp_in; v.wim_ld = wim_ld; v.wim_in = wim_in;
      v.ra = ra; v.rb = rb; v.exp_pa = exp_pa; v.exp_pb = exp_pb; v.exp_cwp = exp_cwp;
      v.exp_wim = exp_wim; v.exp_wovf = exp_wovf; v.exp_wunf = exp_wunf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.Ld = 1'b0; bus.C = 5'd0; bus.PC = '0;
      bus.Save = 1'b0; bus.Restore = 1'b0;
      bus.Cwp_ld = 1'b0; bus.Cwp_in = '0;
      bus.Wim_ld = 1'b0; bus.Wim_in = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles from reset release until Busy falls, bounded.
   task automatic count_clear(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.Busy && n < 300);
   endtask

   int n;

   initial begin
      idle_inputs();
      bus.RA = 5'd0;
      bus.RB = 5'd0;
      #1;
      chk("reset_busy", 32'(bus.Busy), 32'd1);
      chk("reset_cwp",  32'(bus.Cwp),  32'd0);
      chk("reset_wim",  32'(bus.Wim),  32'd0);
      chk("reset_wovf", 32'(bus.Wovf), 32'd0);
      chk("reset_wunf", 32'(bus.Wunf), 32'd0);

      // Release, then re-assert reset after 30 cycles while driving ignored requests.
      tick();
      clr_n = 1'b1;
      bus.Ld = 1'b1; bus.C = 5'd5; bus.PC = 32'hA5A5A5A5;
      bus.Save = 1'b1; bus.Cwp_ld = 1'b1; bus.Cwp_in = 2'd2;
      bus.Wim_ld = 1'b1; bus.Wim_in = 4'hF;
      bus.RA = 5'd5;
      for (int i = 0; i < 30; i++) tick();
      chk("busy_pa_zero",   bus.PA, 32'd0);
      chk("busy_cwp_ign",   32'(bus.Cwp), 32'd0);
      chk("busy_wim_ign",   32'(bus.Wim), 32'd0);
      chk("busy_mid_clear", 32'(bus.Busy), 32'd1);
      clr_n = 1'b0;
      #1;
      chk("midreset_busy", 32'(bus.Busy), 32'd1);
      tick();
      clr_n = 1'b1;
      count_clear(n);
      chk("clear_cycles", 32'(n), 32'd71);
      idle_inputs();
      chk("post_clear_cwp", 32'(bus.Cwp), 32'd0);
      chk("post_clear_wim", 32'(bus.Wim), 32'd0);

      clr_n = 1'b0;
      tick();
      clr_n = 1'b1;
      count_clear(n);
      chk("clear_cycles_2", 32'(n), 32'd71);

      for (int r = 0; r < 32; r++) begin
         bus.RA = 5'(r);
         bus.RB = 5'(31 - r);
         #1;
         chk($sformatf("clear_ra_r%0d", r), bus.PA, 32'd0);
         chk($sformatf("clear_rb_r%0d", 31 - r), bus.PB, 32'd0);
      end

      //                  ld c      pc            sv rs cl ci    wl wi     ra     rb     exp_pa        exp_pb        cwp   wim   ov un
      vecs.push_back(mk(1, 5'd16, 32'hDEADBEEF, 0, 0, 0, 2'd0, 0, 4'h0, 5'd16, 5'd0,  32'hDEADBEEF, 32'h0,        2'd0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        1, 0, 0, 2'd0, 0, 4'h0, 5'd16, 5'd0,  32'h0,        32'h0,        2'd3, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 1, 0, 2'd0, 0, 4'h0, 5'd16, 5'd0,  32'hDEADBEEF, 32'h0,        2'd0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 2'd1, 0, 4'h0, 5'd16, 5'd0,  32'h0,        32'h0,        2'd1, 4'h0, 0, 0));
      vecs.push_back(mk(1, 5'd8,  32'h11111111, 0, 0, 0, 2'd0, 0, 4'h0, 5'd8,  5'd24, 32'h11111111, 32'h0,        2'd1, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        1, 0, 0, 2'd0, 0, 4'h0, 5'd16, 5'd24, 32'hDEADBEEF, 32'h11111111, 2'd0, 4'h0, 0, 0));
      vecs.push_back(mk(1, 5'd8,  32'h22222222, 0, 0, 0, 2'd0, 0, 4'h0, 5'd8,  5'd24, 32'h22222222, 32'h11111111, 2'd0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 2'd3, 0, 4'h0, 5'd24, 5'd8,  32'h22222222, 32'h0,        2'd3, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 2'd0, 1, 4'h8, 5'd0,  5'd0,  32'h0,        32'h0,        2'd0, 4'h8, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        1, 0, 0, 2'd0, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd0, 4'h8, 1, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 0, 0, 2'd0, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd0, 4'h8, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 2'd2, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd2, 4'h8, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 1, 0, 2'd0, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd2, 4'h8, 0, 1));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 0, 0, 2'd0, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd2, 4'h8, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 2'd1, 1, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd1, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        1, 1, 0, 2'd0, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd1, 4'h0, 0, 0));
      vecs.push_back(mk(1, 5'd0,  32'hFFFFFFFF, 0, 0, 0, 2'd0, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd1, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 0, 1, 2'd0, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd0, 4'h0, 0, 0));
      vecs.push_back(mk(1, 5'd5,  32'h00000005, 0, 0, 0, 2'd0, 0, 4'h0, 5'd5,  5'd0,  32'h00000005, 32'h0,        2'd0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        1, 0, 0, 2'd0, 0, 4'h0, 5'd5,  5'd0,  32'h00000005, 32'h0,        2'd3, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        1, 0, 0, 2'd0, 0, 4'h0, 5'd5,  5'd16, 32'h00000005, 32'h0,        2'd2, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        1, 0, 0, 2'd0, 1, 4'h2, 5'd0,  5'd0,  32'h0,        32'h0,        2'd1, 4'h2, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        1, 0, 0, 2'd0, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd0, 4'h2, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 1, 0, 2'd0, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd0, 4'h2, 0, 1));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 0, 0, 2'd0, 1, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd0, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        1, 0, 1, 2'd3, 0, 4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        2'd3, 4'h0, 0, 0));
      vecs.push_back(mk(0, 5'd0,  32'h0,        0, 1, 0, 2'd0, 0, 4'h0, 5'd16, 5'd0,  32'hDEADBEEF, 32'h0,        2'd0, 4'h0, 0, 0));

      foreach (vecs[i]) begin
         bus.Ld = vecs[i].ld; bus.C = vecs[i].c; bus.PC = vecs[i].pc;
         bus.Save = vecs[i].save; bus.Restore = vecs[i].restore;
         bus.Cwp_ld = vecs[i].cwp_ld; bus.Cwp_in = vecs[i].cwp_in;
         bus.Wim_ld = vecs[i].wim_ld; bus.Wim_in = vecs[i].wim_in;
         tick();
         idle_inputs();
         bus.RA = vecs[i].ra;
         bus.RB = vecs[i].rb;
         #1;
         chk($sformatf("v%0d_pa", i),   bus.PA,          vecs[i].exp_pa);
         chk($sformatf("v%0d_pb", i),   bus.PB,          vecs[i].exp_pb);
         chk($sformatf("v%0d_cwp", i),  32'(bus.Cwp),    32'(vecs[i].exp_cwp));
         chk($sformatf("v%0d_wim", i),  32'(bus.Wim),    32'(vecs[i].exp_wim));
         chk($sformatf("v%0d_wovf", i), 32'(bus.Wovf),   32'(vecs[i].exp_wovf));
         chk($sformatf("v%0d_wunf", i), 32'(bus.Wunf),   32'(vecs[i].exp_wunf));
      end

      // Write with Save in the same cycle lands in the pre-edge window; no read bypass.
      bus.Cwp_ld = 1'b1; bus.Cwp_in = 2'd2;
      tick();
      idle_inputs();
      bus.Ld = 1'b1; bus.C = 5'd9; bus.PC = 32'h12345678;
      tick();
      idle_inputs();
      bus.Ld = 1'b1; bus.C = 5'd9; bus.PC = 32'hCAFEF00D; bus.Save = 1'b1;
      bus.RA = 5'd9;
      #1;
      chk("sim_old_value", bus.PA, 32'h12345678);
      chk("sim_pre_cwp",   32'(bus.Cwp), 32'd2);
      tick();
      idle_inputs();
      bus.RA = 5'd25;
      bus.RB = 5'd9;
      #1;
      chk("sim_new_cwp", 32'(bus.Cwp), 32'd1);
      chk("sim_r25",     bus.PA, 32'hCAFEF00D);
      chk("sim_r9_new",  bus.PB, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
